// File: rtl/pifo_task_pkg.sv
// Shared widths, task opcode and task record for the PIFO command intake.
package pifo_task_pkg;

    localparam int PTW   = 8;
    localparam int MTW   = 0;
    localparam int DW    = PTW + MTW;
    localparam int LEVEL = 4;
    localparam int TIDW  = 2;
    localparam int DEPTH = 4;
    localparam int LVLW  = (LEVEL > 1) ? $clog2(LEVEL) : 1;
    localparam int CNTW  = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        OP_NONE    = 2'd0,
        OP_PUSH    = 2'd1,
        OP_POP     = 2'd2,
        OP_PUSHPOP = 2'd3
    } task_op_t;

    typedef struct packed {
        task_op_t            op;
        logic [TIDW-1:0]     tree_id;
        logic [DW-1:0]       data;
    } task_t;

    // Bit 0 is push and bit 1 is pop, so both together give OP_PUSHPOP.
    function automatic task_op_t encode_op(input logic push, input logic pop);
        return task_op_t'({pop, push});
    endfunction

endpackage

// File: rtl/pifo_task_intake_if.sv
// Per-level command bus and merged task stream of the PIFO intake.
interface pifo_task_intake_if;
    import pifo_task_pkg::*;

    logic [LEVEL-1:0]            i_push;
    logic [LEVEL-1:0]            i_pop;
    logic [LEVEL-1:0][DW-1:0]    i_push_data;
    logic [LEVEL-1:0][TIDW-1:0]  i_tree_id;
    logic [LEVEL-1:0]            o_task_fifo_full;
    logic [LEVEL-1:0]            o_overflow;

    // Task stream: a task moves only on a cycle with o_task_valid && i_task_ready;
    // while o_task_valid is high and i_task_ready low every o_task_* field holds
    // steady, and o_task_valid never depends combinationally on i_task_ready.
    logic                        o_task_valid;
    logic                        i_task_ready;
    logic [LVLW-1:0]             o_task_level;
    task_op_t                    o_task_op;
    logic [TIDW-1:0]             o_task_tree_id;
    logic [DW-1:0]               o_task_data;

    modport slave (
        input  i_push, i_pop, i_push_data, i_tree_id, i_task_ready,
        output o_task_fifo_full, o_overflow, o_task_valid,
               o_task_level, o_task_op, o_task_tree_id, o_task_data
    );

    modport master (
        output i_push, i_pop, i_push_data, i_tree_id, i_task_ready,
        input  o_task_fifo_full, o_overflow, o_task_valid,
               o_task_level, o_task_op, o_task_tree_id, o_task_data
    );

endinterface

// File: rtl/pifo_task_fifo.sv
// Synchronous per-level task FIFO; writes while full and reads while empty are ignored.
module pifo_task_fifo
    import pifo_task_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr,
    input  task_t           wr_data,
    input  logic            rd,
    output logic            full,
    output logic            empty,
    output logic [CNTW-1:0] count,
    output task_t           head
);

    localparam int PW = $clog2(DEPTH);

    task_t         mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    // Room is judged on the pre-edge count, so a read on a full FIFO frees nothing this edge.
    assign wr_en = wr && !full;
    assign rd_en = rd && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign full  = (count == CNTW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/pifo_task_intake.sv
// PIFO command intake: per-level task FIFOs merged round-robin into one registered task stream.
module pifo_task_intake
    import pifo_task_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_arst_n,
    pifo_task_intake_if.slave  bus
);

    logic [LEVEL-1:0] cmd;
    logic [LEVEL-1:0] fifo_rd;
    logic [LEVEL-1:0] fifo_full;
    logic [LEVEL-1:0] fifo_empty;
    logic [CNTW-1:0]  fifo_count [LEVEL];
    task_t            fifo_head  [LEVEL];
    task_t            cmd_task   [LEVEL];

    logic             any_ready;
    logic [LVLW-1:0]  grant;
    logic [LVLW-1:0]  arb_idx;
    logic             load;

    logic [LVLW-1:0]  rr_ptr;
    logic             out_valid;
    logic [LVLW-1:0]  out_level;
    task_t            out_task;
    logic [LEVEL-1:0] overflow;

    for (genvar g = 0; g < LEVEL; g++) begin : g_level
        assign cmd[g]      = bus.i_push[g] | bus.i_pop[g];
        assign cmd_task[g] = '{op:      encode_op(bus.i_push[g], bus.i_pop[g]),
                               tree_id: bus.i_tree_id[g],
                               data:    bus.i_push_data[g]};

        pifo_task_fifo u_fifo (
            .clk     (i_clk),
            .rst_n   (i_arst_n),
            .wr      (cmd[g]),
            .wr_data (cmd_task[g]),
            .rd      (fifo_rd[g]),
            .full    (fifo_full[g]),
            .empty   (fifo_empty[g]),
            .count   (fifo_count[g]),
            .head    (fifo_head[g])
        );

        assign bus.o_task_fifo_full[g] = (fifo_count[g] == CNTW'(DEPTH));
    end

    // First non-empty level at or after the round-robin pointer wins.
    always_comb begin
        any_ready = 1'b0;
        grant     = '0;
        arb_idx   = '0;
        for (int i = 0; i < LEVEL; i++) begin
            arb_idx = LVLW'((int'(rr_ptr) + i) % LEVEL);
            if (!any_ready && !fifo_empty[arb_idx]) begin
                any_ready = 1'b1;
                grant     = arb_idx;
            end
        end
    end

    assign load    = (!out_valid || bus.i_task_ready) && any_ready;
    assign fifo_rd = load ? (LEVEL'(1) << grant) : '0;

    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            out_valid <= 1'b0;
            out_level <= '0;
            out_task  <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_level <= grant;
            out_task  <= fifo_head[grant];
            rr_ptr    <= (grant == LVLW'(LEVEL - 1)) ? '0 : grant + 1'b1;
        end else if (bus.i_task_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky until reset: a command was dropped because its level was full.
    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            overflow <= '0;
        end else begin
            overflow <= overflow | (cmd & fifo_full);
        end
    end

    assign bus.o_overflow     = overflow;
    assign bus.o_task_valid   = out_valid;
    assign bus.o_task_level   = out_level;
    assign bus.o_task_op      = out_task.op;
    assign bus.o_task_tree_id = out_task.tree_id;
    assign bus.o_task_data    = out_task.data;

endmodule
